// File: rtl/player_bullet_pkg.sv
// Shared defaults and state encoding for the player bullet controller.
package params;

    localparam int BULLET_W        = 4;   // bullet width, pixels
    localparam int BULLET_H        = 12;  // bullet height, pixels
    localparam int BULLET_SPEED    = 8;   // upward pixels per frame
    localparam int COOLDOWN_FRAMES = 8;   // frames between retire and next shot

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLIGHT   = 2'd1,
        COOLDOWN = 2'd2
    } player_bullet_state_t;

endpackage

// File: rtl/player_bullet_fire_sync.sv
// Fire button synchronizer: two metastability flops followed by a delayed
// copy used for rising-edge detection. fire_edge is a one-cycle pulse.
module fire_sync (
    input  logic pixel_clk,
    input  logic rst_n,
    input  logic fire_btn,
    output logic fire_edge
);

    logic sync_meta;
    logic sync_q;
    logic sync_prev;

    // Synchronize the raw button and keep one extra stage for edge detection.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_meta <= fire_btn;
            sync_q    <= sync_meta;
            sync_prev <= sync_q;
        end
    end

    // Rising edge of the synchronized button.
    always_comb begin
        fire_edge = sync_q & ~sync_prev;
    end

endmodule

// File: rtl/player_bullet.sv
// Player-side projectile controller: spawns one bullet above the paddle on a
// synchronized fire press, moves it up once per frame, retires it on an alien
// hit or when it leaves the top of the screen, and renders it white.
//
// Optional feature macro: PLAYER_BULLET_COOLDOWN_EN
//   defined   - a COOLDOWN state waits COOLDOWN_FRAMES frame strobes after
//               each retire before the next shot is accepted.
//   undefined - a retire returns straight to IDLE; COOLDOWN_FRAMES is unused.
//
// state_dbg exposes the FSM state (player_bullet_state_t encoding).
module player_bullet
    import params::*;
#(
    parameter int BULLET_W        = params::BULLET_W,
    parameter int BULLET_H        = params::BULLET_H,
    parameter int BULLET_SPEED    = params::BULLET_SPEED,
    parameter int COOLDOWN_FRAMES = params::COOLDOWN_FRAMES
) (
    input  logic               pixel_clk,
    input  logic               rst_n,
    input  logic               fsync,
    input  logic signed [11:0] hpos,
    input  logic signed [11:0] vpos,
    input  logic               fire_btn,
    input  logic signed [11:0] paddle_left,
    input  logic signed [11:0] paddle_right,
    input  logic signed [11:0] paddle_top,
    input  logic               alien_hit,
    output logic               bullet_active,
    output logic signed [11:0] bullet_left,
    output logic signed [11:0] bullet_right,
    output logic signed [11:0] bullet_top,
    output logic signed [11:0] bullet_bottom,
    output logic [7:0]         pixel [0:2],
    output logic               active,
    output logic [15:0]        shots_fired,
    output logic [1:0]         state_dbg
);

`ifdef PLAYER_BULLET_COOLDOWN_EN
    localparam player_bullet_state_t RETIRE_STATE = COOLDOWN;
    localparam logic [15:0]          CD_LAST      = 16'(COOLDOWN_FRAMES - 1);
`else
    localparam player_bullet_state_t RETIRE_STATE = IDLE;
`endif

    player_bullet_state_t state;
    player_bullet_state_t state_nxt;

    logic fire_edge;
    logic fire_pending;

    logic do_spawn;
    logic do_move;
    logic do_retire;

`ifdef PLAYER_BULLET_COOLDOWN_EN
    logic [15:0] cd_cnt;
    logic        cd_inc;
    logic        cd_clr;
`endif

    // 13-bit intermediates so paddle sums and subtractions cannot overflow
    // before the result is truncated back to 12 bits.
    logic signed [12:0] paddle_sum;
    logic signed [12:0] paddle_mid;
    logic signed [12:0] spawn_left13;
    logic signed [12:0] spawn_right13;
    logic signed [12:0] spawn_top13;
    logic signed [12:0] spawn_bottom13;
    logic signed [12:0] moved_top13;
    logic signed [12:0] moved_bottom13;
    logic signed [11:0] moved_top;
    logic signed [11:0] moved_bottom;

    fire_sync u_fire_sync (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .fire_btn  (fire_btn),
        .fire_edge (fire_edge)
    );

    // Spawn geometry from the paddle and the one-frame upward move.
    always_comb begin
        paddle_sum     = {paddle_left[11], paddle_left} + {paddle_right[11], paddle_right};
        paddle_mid     = paddle_sum >>> 1;
        spawn_left13   = paddle_mid - $signed(13'(BULLET_W / 2));
        spawn_right13  = {spawn_left13[11], spawn_left13[11:0]} + $signed(13'(BULLET_W - 1));
        spawn_top13    = {paddle_top[11], paddle_top} - $signed(13'(BULLET_H));
        spawn_bottom13 = {spawn_top13[11], spawn_top13[11:0]} + $signed(13'(BULLET_H - 1));
        moved_top13    = {bullet_top[11], bullet_top} - $signed(13'(BULLET_SPEED));
        moved_top      = moved_top13[11:0];
        moved_bottom13 = {moved_top[11], moved_top} + $signed(13'(BULLET_H - 1));
        moved_bottom   = moved_bottom13[11:0];
    end

    // FSM state register.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath strobes; a hit outranks a coincident frame move.
    always_comb begin
        state_nxt = state;
        do_spawn  = 1'b0;
        do_move   = 1'b0;
        do_retire = 1'b0;
`ifdef PLAYER_BULLET_COOLDOWN_EN
        cd_inc    = 1'b0;
        cd_clr    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (fsync && fire_pending) begin
                    do_spawn  = 1'b1;
                    state_nxt = FLIGHT;
                end
            end
            FLIGHT: begin
                if (alien_hit) begin
                    do_retire = 1'b1;
                    state_nxt = RETIRE_STATE;
                end else if (fsync) begin
                    do_move = 1'b1;
                    if (moved_bottom < 0) begin
                        do_retire = 1'b1;
                        state_nxt = RETIRE_STATE;
                    end
                end
            end
`ifdef PLAYER_BULLET_COOLDOWN_EN
            COOLDOWN: begin
                if (fsync) begin
                    if (cd_cnt >= CD_LAST) begin
                        cd_clr    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        cd_inc = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef PLAYER_BULLET_COOLDOWN_EN
    // Count frame strobes spent in COOLDOWN.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            cd_cnt <= 16'd0;
        end else if (cd_clr) begin
            cd_cnt <= 16'd0;
        end else if (cd_inc) begin
            cd_cnt <= cd_cnt + 16'd1;
        end
    end
`endif

    // Latch a fire press only while idle; the spawn consumes it.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            fire_pending <= 1'b0;
        end else if (do_spawn) begin
            fire_pending <= 1'b0;
        end else if (fire_edge && (state == IDLE)) begin
            fire_pending <= 1'b1;
        end
    end

    // Bullet bounds, flight flag and shot counter. Bounds keep their last
    // value after a retire; the exit move still lands before retiring.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            bullet_active <= 1'b0;
            bullet_left   <= '0;
            bullet_right  <= '0;
            bullet_top    <= '0;
            bullet_bottom <= '0;
            shots_fired   <= 16'd0;
        end else begin
            if (do_spawn) begin
                bullet_active <= 1'b1;
                bullet_left   <= spawn_left13[11:0];
                bullet_right  <= spawn_right13[11:0];
                bullet_top    <= spawn_top13[11:0];
                bullet_bottom <= spawn_bottom13[11:0];
                if (shots_fired != 16'hFFFF) begin
                    shots_fired <= shots_fired + 16'd1;
                end
            end
            if (do_move) begin
                bullet_top    <= moved_top;
                bullet_bottom <= moved_bottom;
            end
            if (do_retire) begin
                bullet_active <= 1'b0;
            end
        end
    end

    // Raster hit test against the registered bounds and the white fill.
    always_comb begin
        active = bullet_active
              && (hpos >= bullet_left) && (hpos <= bullet_right)
              && (vpos >= bullet_top)  && (vpos <= bullet_bottom);
        for (int i = 0; i < 3; i++) begin
            pixel[i] = active ? 8'hFF : 8'h00;
        end
        state_dbg = state;
    end

endmodule

// File: tb/tb_player_bullet.sv
// Directed bench for player_bullet: spawn geometry, flight and exit, hit
// priority, cooldown (or its absence), rendering window and async reset.
module tb_player_bullet;
    import params::*;

    logic               pixel_clk;
    logic               rst_n;
    logic               fsync;
    logic signed [11:0] hpos;
    logic signed [11:0] vpos;
    logic               fire_btn;
    logic signed [11:0] paddle_left;
    logic signed [11:0] paddle_right;
    logic signed [11:0] paddle_top;
    logic               alien_hit;
    logic               bullet_active;
    logic signed [11:0] bullet_left;
    logic signed [11:0] bullet_right;
    logic signed [11:0] bullet_top;
    logic signed [11:0] bullet_bottom;
    logic [7:0]         pixel [0:2];
    logic               active;
    logic [15:0]        shots_fired;
    logic [1:0]         state_dbg;

    int checks;
    int failures;

`ifdef PLAYER_BULLET_COOLDOWN_EN
    localparam int RETIRED_STATE = int'(COOLDOWN);
`else
    localparam int RETIRED_STATE = int'(IDLE);
`endif

    player_bullet dut (
        .pixel_clk     (pixel_clk),
        .rst_n         (rst_n),
        .fsync         (fsync),
        .hpos          (hpos),
        .vpos          (vpos),
        .fire_btn      (fire_btn),
        .paddle_left   (paddle_left),
        .paddle_right  (paddle_right),
        .paddle_top    (paddle_top),
        .alien_hit     (alien_hit),
        .bullet_active (bullet_active),
        .bullet_left   (bullet_left),
        .bullet_right  (bullet_right),
        .bullet_top    (bullet_top),
        .bullet_bottom (bullet_bottom),
        .pixel         (pixel),
        .active        (active),
        .shots_fired   (shots_fired),
        .state_dbg     (state_dbg)
    );

    // Clock
    initial begin
        pixel_clk = 1'b0;
        forever #5 pixel_clk = ~pixel_clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic fsync_pulse();
        fsync = 1'b1;
        tick();
        fsync = 1'b0;
        tick();
    endtask

    task automatic press();
        fire_btn = 1'b1;
        repeat (4) tick();
        fire_btn = 1'b0;
        tick();
    endtask

    int rh [8] = '{100, 103, 101, 103,  99, 104, 100, 100};
    int rv [8] = '{ 50,  61,  55,  50,  50,  50,  49,  62};
    int re [8] = '{  1,   1,   1,   1,   0,   0,   0,   0};

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; fsync = 1'b0; fire_btn = 1'b0; alien_hit = 1'b0;
        hpos = '0; vpos = '0;
        paddle_left = 12'sd300; paddle_right = 12'sd339; paddle_top = 12'sd440;
        #23;
        check("rst_active", int'(bullet_active), 0);
        check("rst_left", int'(bullet_left), 0);
        check("rst_bottom", int'(bullet_bottom), 0);
        check("rst_shots", int'(shots_fired), 0);
        check("rst_pixel", int'(pixel[1]), 0);
        check("rst_state", int'(state_dbg), int'(IDLE));
        rst_n = 1'b1;
        tick();

        // Spawn above paddle 300..339, top 440
        press();
        fsync_pulse();
        check("spawn_active", int'(bullet_active), 1);
        check("spawn_left", int'(bullet_left), 317);
        check("spawn_right", int'(bullet_right), 320);
        check("spawn_top", int'(bullet_top), 428);
        check("spawn_bottom", int'(bullet_bottom), 439);
        check("spawn_shots", int'(shots_fired), 1);
        check("spawn_state", int'(state_dbg), int'(FLIGHT));

        // Flight to the top edge and exit
        repeat (54) fsync_pulse();
        check("fly_top", int'(bullet_top), -4);
        check("fly_active", int'(bullet_active), 1);
        fsync_pulse();
        check("exit_top", int'(bullet_top), -12);
        check("exit_bottom", int'(bullet_bottom), -1);
        check("exit_active", int'(bullet_active), 0);
        check("exit_state", int'(state_dbg), RETIRED_STATE);

        paddle_top = 12'sd244;
`ifdef PLAYER_BULLET_COOLDOWN_EN
        // Presses during cooldown frames 1..7 are discarded
        for (int i = 0; i < 7; i++) begin
            press();
            fsync_pulse();
        end
        check("cd_noshot", int'(bullet_active), 0);
        check("cd_state", int'(state_dbg), int'(COOLDOWN));
        fsync_pulse();
        check("cd_done_state", int'(state_dbg), int'(IDLE));
        fsync_pulse();
        check("cd_no_pending", int'(bullet_active), 0);
        check("cd_shots", int'(shots_fired), 1);
`endif
        press();
        fsync_pulse();
        check("respawn_active", int'(bullet_active), 1);
        check("respawn_top", int'(bullet_top), 232);
        check("respawn_shots", int'(shots_fired), 2);

        // Geometry is not re-sampled during flight
        paddle_top = 12'sd0; paddle_left = 12'sd0; paddle_right = 12'sd0;
        repeat (4) fsync_pulse();
        check("fly200_top", int'(bullet_top), 200);
        check("fly200_left", int'(bullet_left), 317);

        // Hit coincident with fsync: retire at pre-move position
        alien_hit = 1'b1; fsync = 1'b1;
        tick();
        alien_hit = 1'b0; fsync = 1'b0;
        check("hit_active", int'(bullet_active), 0);
        check("hit_top", int'(bullet_top), 200);
        check("hit_bottom", int'(bullet_bottom), 211);
        check("hit_state", int'(state_dbg), RETIRED_STATE);
        tick();

        // Clear any cooldown, then spawn at left=100 top=50
        repeat (8) fsync_pulse();
        paddle_left = 12'sd80; paddle_right = 12'sd124; paddle_top = 12'sd62;
        press();
        fsync_pulse();
        check("rnd_left", int'(bullet_left), 100);
        check("rnd_top", int'(bullet_top), 50);
        check("rnd_shots", int'(shots_fired), 3);
        for (int i = 0; i < 8; i++) begin
            hpos = 12'(rh[i]); vpos = 12'(rv[i]);
            #1;
            check($sformatf("rnd_active_%0d_%0d", rh[i], rv[i]), int'(active), re[i]);
            check($sformatf("rnd_pix_%0d_%0d", rh[i], rv[i]), int'(pixel[0]), re[i] ? 255 : 0);
        end

        // Asynchronous reset mid-flight
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_active", int'(bullet_active), 0);
        check("arst_left", int'(bullet_left), 0);
        check("arst_top", int'(bullet_top), 0);
        check("arst_shots", int'(shots_fired), 0);
        check("arst_pixel", int'(pixel[2]), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_state", int'(state_dbg), int'(IDLE));
        fsync_pulse();
        check("arst_nospawn", int'(bullet_active), 0);

        // Negative paddle coordinates exercise the signed midpoint
        paddle_left = -12'sd10; paddle_right = 12'sd5; paddle_top = 12'sd20;
        press();
        fsync_pulse();
        check("neg_left", int'(bullet_left), -5);
        check("neg_right", int'(bullet_right), -2);
        check("neg_top", int'(bullet_top), 8);
        check("neg_bottom", int'(bullet_bottom), 19);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
